intr_ctrl_vec: RTL and testbench
================================

// Module: intr_ctrl_vec
// PURPOSE
//  Parametrised vectored interrupt controller: next generation of the core's single interrupt line.
//  Sits between external IRQ sources and the CPU fetch/decode interrupt path.
//  Provides N prioritised, maskable, edge/level channels with nesting up to NEST_DEPTH.
//  Hands the core a vector address and tracks in-service channels via ack/return pulses.
// PARAMETERS
//  NUM_IRQ     8      number of interrupt channels (2..16); index 0 = highest priority
//  DATA_W      8      vector/address width
//  VEC_BASE    8'hF0  vector of channel 0
//  VEC_STRIDE  1      vector spacing between channels
//  EDGE_MASK   all 1  per-channel mode: 1 = rising-edge, 0 = level
//  NEST_DEPTH  2      max in-service channels held on the internal priority stack (1..4)
// PORTS
//  clk           in   1        system clock; all logic on rising edge
//  reset         in   1        synchronous, active-low reset (0 = reset)
//  irq_in        in   NUM_IRQ  interrupt sources, synchronous to clk
//  cfg_mask_we   in   1        load mask register from cfg_wdata
//  cfg_clr_we    in   1        clear pending bits set in cfg_wdata (edge channels only)
//  cfg_wdata     in   NUM_IRQ  config write data
//  intr_ack      in   1        1-cycle pulse: core has taken the request (PC pushed)
//  intr_ret      in   1        1-cycle pulse: core retired RTI
//  intr_req      out  1        request to core; held until ack or withdrawal
//  intr_vec      out  DATA_W   vector of requested channel; stable while intr_req=1
//  active_valid  out  1        at least one channel in service
//  active_id     out  4        top-of-stack channel id
//  pending       out  NUM_IRQ  pending register (unmasked view)
//  spurious_ret  out  1        1-cycle pulse: intr_ret with empty stack
// BEHAVIOUR
//  Reset (reset=0 at a clk edge): mask = all 1 (all masked), pending = 0, stack empty,
//   intr_req=0, intr_vec=0, active_valid=0, active_id=0, spurious_ret=0, edge history = 0.
//   Reset mid-request drops intr_req the next cycle; no ack is expected.
//  Pending: edge channel sets on irq_in 0->1 (prev-cycle sample vs current); cleared by ack of
//   that channel or cfg_clr_we. Set and clear in same cycle -> set wins.
//   Level channel: pending bit = irq_in registered; not clearable; ack does not clear it.
//  Eligible = pending & ~mask & (id < active_id, or stack empty); winner = lowest eligible index.
//  FSM states: IDLE, REQ.
//   IDLE: if winner exists and stack not full -> latch id, intr_vec = VEC_BASE + id*VEC_STRIDE
//    (mod 2^DATA_W), intr_req=1, go REQ. Stack full -> stay IDLE regardless of priority.
//   REQ: latched id frozen (no retarget to higher-priority arrivals).
//    intr_ack -> push id, clear edge pending, intr_req=0, -> IDLE.
//    latched channel masked (or level source dropped) before ack -> intr_req=0, -> IDLE.
//  Latency: edge sampled at cycle t -> pending at t+1 -> intr_req at t+2. Ack at t -> next req
//   earliest t+2.
//  intr_ack outside REQ: ignored.
//  intr_ret: pop stack; active_id = new top (0 if empty). Empty stack -> no pop, spurious_ret=1
//   for 1 cycle.
//  intr_ret and intr_ack same cycle: pop applied first, then push; net depth unchanged.
//  Mask write takes effect on eligibility the following cycle; pending bits untouched.
// TESTING
//  1. Unmask ch3 (edge), pulse irq_in[3] at t -> intr_req=1, intr_vec=8'hF3 at t+2; ack -> pending[3]=0.
//  2. irq 2 and 5 rise same cycle -> vector F2 first; ack, ret -> vector F5 follows.
//  3. Nesting: ch4 in service, ch1 rises -> req F1, ack -> active_id=1; ret -> active_id=4;
//     ret -> active_valid=0.
//  4. Stack full (depth 2: ch6, ch3 in service), ch0 rises -> intr_req stays 0 until a ret.
//  5. Level ch7 (EDGE_MASK[7]=0) held high, masked during REQ -> intr_req drops next cycle.
//  6. intr_ret with empty stack -> spurious_ret=1 one cycle; reset=0 during REQ -> all outputs 0.

Source files
------------

// File: rtl/intr_ctrl_vec.sv
`default_nettype none
// ============================================================================
// Module  : intr_ctrl_vec
// Brief   : Vectored, prioritised, maskable interrupt controller with a small
//           nesting stack of in-service channels.
// Revision: 1.0  initial release
// ============================================================================
module intr_ctrl_vec #(
   parameter int unsigned          NUM_IRQ    = 8,
   parameter int unsigned          DATA_W     = 8,
   parameter logic [DATA_W-1:0]    VEC_BASE   = DATA_W'(8'hF0),
   parameter int unsigned          VEC_STRIDE = 1,
   parameter logic [NUM_IRQ-1:0]   EDGE_MASK  = '1,
   parameter int unsigned          NEST_DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               cfg_mask_we,
   input  logic               cfg_clr_we,
   input  logic [NUM_IRQ-1:0] cfg_wdata,
   input  logic               intr_ack,
   input  logic               intr_ret,
   output logic               intr_req,
   output logic [DATA_W-1:0]  intr_vec,
   output logic               active_valid,
   output logic [3:0]         active_id,
   output logic [NUM_IRQ-1:0] pending,
   output logic               spurious_ret
);

   localparam int unsigned        IDW     = $clog2(NUM_IRQ);
   localparam int unsigned        DEPTH_W = $clog2(NEST_DEPTH + 1);
   localparam logic [DEPTH_W-1:0] FULL    = DEPTH_W'(NEST_DEPTH);
   localparam logic [DEPTH_W-1:0] ONE     = DEPTH_W'(1);
   localparam logic [DATA_W-1:0]  STRIDE  = DATA_W'(VEC_STRIDE);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   state_t              state_q;
   logic [NUM_IRQ-1:0]  irq_prev_q;
   logic [NUM_IRQ-1:0]  pending_q, pending_d;
   logic [NUM_IRQ-1:0]  mask_q;
   logic [3:0]          stack_q [NEST_DEPTH];
   logic [3:0]          stack_d [NEST_DEPTH];
   logic [DEPTH_W-1:0]  depth_q, depth_d;
   logic [3:0]          req_id_q;
   logic                intr_req_q;
   logic [DATA_W-1:0]   intr_vec_q;
   logic                spurious_q;

   logic                ack_take;
   logic [NUM_IRQ-1:0]  eligible;
   logic                win_valid;
   logic [3:0]          win_id;
   logic                withdraw;

   assign ack_take = (state_q == REQ) && intr_ack;

   // Only edge channels latch; level channels simply mirror the registered source.
   always_comb begin
      pending_d = pending_q;
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
         if (EDGE_MASK[i]) begin
            if ((ack_take && (req_id_q == 4'(i))) || (cfg_clr_we && cfg_wdata[i]))
               pending_d[i] = 1'b0;
            if (irq_in[i] && !irq_prev_q[i])
               pending_d[i] = 1'b1;
         end else begin
            pending_d[i] = irq_in[i];
         end
      end
   end

   always_comb begin
      eligible = '0;
      for (int i = 0; i < int'(NUM_IRQ); i++)
         eligible[i] = pending_q[i] & ~mask_q[i] &
                       ((depth_q == '0) | (4'(i) < stack_q[0]));
      win_valid = |eligible;
      win_id    = '0;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--)
         if (eligible[i]) win_id = 4'(i);
   end

   // Top of stack lives at index 0; a return and an ack in one cycle pop then push.
   always_comb begin
      stack_d = stack_q;
      depth_d = depth_q;
      if (intr_ret && (depth_q != '0)) begin
         for (int i = 0; i < int'(NEST_DEPTH) - 1; i++)
            stack_d[i] = stack_q[i+1];
         stack_d[NEST_DEPTH-1] = '0;
         depth_d = depth_q - ONE;
      end
      if (ack_take) begin
         for (int i = int'(NEST_DEPTH) - 1; i > 0; i--)
            stack_d[i] = stack_d[i-1];
         stack_d[0] = req_id_q;
         depth_d    = depth_d + ONE;
      end
   end

   assign withdraw = mask_q[req_id_q[IDW-1:0]] |
                     (~EDGE_MASK[req_id_q[IDW-1:0]] & ~pending_q[req_id_q[IDW-1:0]]);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         req_id_q   <= '0;
         intr_req_q <= 1'b0;
         intr_vec_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_valid && (depth_q != FULL)) begin
                  req_id_q   <= win_id;
                  intr_vec_q <= VEC_BASE + DATA_W'(win_id) * STRIDE;
                  intr_req_q <= 1'b1;
                  state_q    <= REQ;
               end
            end
            REQ: begin
               if (intr_ack || withdraw) begin
                  intr_req_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         irq_prev_q <= '0;
         pending_q  <= '0;
         mask_q     <= '1;
         depth_q    <= '0;
         spurious_q <= 1'b0;
         for (int i = 0; i < int'(NEST_DEPTH); i++)
            stack_q[i] <= '0;
      end else begin
         irq_prev_q <= irq_in;
         pending_q  <= pending_d;
         if (cfg_mask_we)
            mask_q <= cfg_wdata;
         depth_q    <= depth_d;
         spurious_q <= intr_ret && (depth_q == '0);
         for (int i = 0; i < int'(NEST_DEPTH); i++)
            stack_q[i] <= stack_d[i];
      end
   end

   assign intr_req     = intr_req_q;
   assign intr_vec     = intr_vec_q;
   assign active_valid = (depth_q != '0);
   assign active_id    = stack_q[0];
   assign pending      = pending_q;
   assign spurious_ret = spurious_q;

endmodule
`default_nettype wire

// File: tb/tb_intr_ctrl_vec.sv
`default_nettype none
// ============================================================================
// Module  : tb_intr_ctrl_vec
// Brief   : Directed and random stimulus for intr_ctrl_vec against a
//           queue-based reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_intr_ctrl_vec;

   localparam logic [7:0] EDGES = 8'h7F;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] irq_in;
   logic       cfg_mask_we, cfg_clr_we;
   logic [7:0] cfg_wdata;
   logic       intr_ack, intr_ret;
   logic       intr_req;
   logic [7:0] intr_vec;
   logic       active_valid;
   logic [3:0] active_id;
   logic [7:0] pending;
   logic       spurious_ret;

   int tests = 0;
   int fails = 0;

   // Reference model state: stack is a queue with the in-service top at the front.
   bit [7:0] m_pend, m_mask, m_prev, m_vec;
   bit       m_req, m_spur;
   int       m_id;
   int       stk[$];

   intr_ctrl_vec #(
      .NUM_IRQ(8), .DATA_W(8), .VEC_BASE(8'hF0), .VEC_STRIDE(1),
      .EDGE_MASK(EDGES), .NEST_DEPTH(2)
   ) dut (
      .clk(clk), .reset(reset), .irq_in(irq_in),
      .cfg_mask_we(cfg_mask_we), .cfg_clr_we(cfg_clr_we), .cfg_wdata(cfg_wdata),
      .intr_ack(intr_ack), .intr_ret(intr_ret),
      .intr_req(intr_req), .intr_vec(intr_vec),
      .active_valid(active_valid), .active_id(active_id),
      .pending(pending), .spurious_ret(spurious_ret)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit [7:0] np;
      int       win;
      bit       ack_ok;
      if (!reset) begin
         m_pend = '0; m_mask = '1; m_prev = '0; m_vec = '0;
         m_req = 0; m_spur = 0; m_id = 0; stk = {};
         return;
      end
      ack_ok = m_req && intr_ack;
      win = -1;
      if (!m_req && stk.size() < 2)
         for (int i = 0; i < 8; i++)
            if (win < 0 && m_pend[i] && !m_mask[i] && (stk.size() == 0 || i < stk[0]))
               win = i;
      for (int i = 0; i < 8; i++) begin
         if (!EDGES[i])
            np[i] = irq_in[i];
         else if (irq_in[i] && !m_prev[i])
            np[i] = 1'b1;
         else if ((ack_ok && m_id == i) || (cfg_clr_we && cfg_wdata[i]))
            np[i] = 1'b0;
         else
            np[i] = m_pend[i];
      end
      m_spur = intr_ret && stk.size() == 0;
      if (intr_ret && stk.size() > 0) void'(stk.pop_front());
      if (ack_ok) stk.push_front(m_id);
      if (m_req) begin
         if (intr_ack || m_mask[m_id] || (!EDGES[m_id] && !m_pend[m_id])) m_req = 0;
      end else if (win >= 0) begin
         m_req = 1; m_id = win; m_vec = 8'hF0 + 8'(win);
      end
      if (cfg_mask_we) m_mask = cfg_wdata;
      m_pend = np;
      m_prev = irq_in;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("req", 32'(intr_req), 32'(m_req));
      check("vec", 32'(intr_vec), 32'(m_vec));
      check("active_valid", 32'(active_valid), 32'(stk.size() != 0));
      check("active_id", 32'(active_id), (stk.size() != 0) ? 32'(stk[0]) : 32'd0);
      check("pending", 32'(pending), 32'(m_pend));
      check("spurious", 32'(spurious_ret), 32'(m_spur));
      intr_ack = 0; intr_ret = 0; cfg_mask_we = 0; cfg_clr_we = 0;
   endtask

   task automatic set_mask(input logic [7:0] m);
      cfg_mask_we = 1; cfg_wdata = m; tick();
   endtask

   task automatic pulse_irq(input logic [7:0] v);
      irq_in = v; tick(); irq_in = '0; tick();
   endtask

   initial begin
      reset = 0; irq_in = '0; cfg_mask_we = 0; cfg_clr_we = 0; cfg_wdata = '0;
      intr_ack = 0; intr_ret = 0;
      @(negedge clk);
      tick(); tick();
      check("rst_req", 32'(intr_req), 0);
      check("rst_vec", 32'(intr_vec), 0);
      check("rst_pend", 32'(pending), 0);
      reset = 1;

      // Single edge channel: vector F3, ack clears pending.
      set_mask(~8'h08);
      irq_in = 8'h08; tick();
      check("t1_pend", 32'(pending[3]), 1);
      irq_in = '0; tick();
      check("t1_vec", 32'(intr_vec), 32'hF3);
      intr_ack = 1; tick();
      check("t1_clr", 32'(pending[3]), 0);
      intr_ret = 1; tick();

      // Simultaneous arrivals: lower index first, the other after return.
      set_mask(~8'h24);
      pulse_irq(8'h24);
      check("t2_first", 32'(intr_vec), 32'hF2);
      intr_ack = 1; tick();
      intr_ret = 1; tick();
      tick();
      check("t2_second", 32'(intr_vec), 32'hF5);
      intr_ack = 1; tick();
      intr_ret = 1; tick();

      // Nesting: ch1 pre-empts ch4.
      set_mask(~8'h12);
      pulse_irq(8'h10);
      intr_ack = 1; tick();
      pulse_irq(8'h02);
      check("t3_vec", 32'(intr_vec), 32'hF1);
      intr_ack = 1; tick();
      check("t3_top1", 32'(active_id), 1);
      intr_ret = 1; tick();
      check("t3_top4", 32'(active_id), 4);
      intr_ret = 1; tick();
      check("t3_empty", 32'(active_valid), 0);

      // Full stack holds off even the highest-priority channel.
      set_mask(~8'h49);
      pulse_irq(8'h40); intr_ack = 1; tick();
      pulse_irq(8'h08); intr_ack = 1; tick();
      pulse_irq(8'h01); tick();
      check("t4_full", 32'(intr_req), 0);
      intr_ret = 1; tick();
      tick();
      check("t4_after", 32'(intr_vec), 32'hF0);
      intr_ack = 1; tick();
      intr_ret = 1; tick();
      intr_ret = 1; tick();

      // Level channel withdrawn by masking while requested.
      irq_in = 8'h80; set_mask(8'h7F);
      tick();
      check("t5_vec", 32'(intr_vec), 32'hF7);
      set_mask(8'hFF);
      tick();
      check("t5_drop", 32'(intr_req), 0);
      irq_in = '0; tick();

      // Spurious return, then reset in the middle of a request.
      intr_ret = 1; tick();
      check("t6_spur", 32'(spurious_ret), 1);
      tick();
      check("t6_spur_off", 32'(spurious_ret), 0);
      set_mask(8'hFD);
      pulse_irq(8'h02);
      check("t6_req", 32'(intr_req), 1);
      reset = 0; tick();
      check("t6_rst_req", 32'(intr_req), 0);
      check("t6_rst_valid", 32'(active_valid), 0);
      reset = 1;

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         irq_in      = 8'($urandom);
         cfg_mask_we = ($urandom_range(15) == 0);
         cfg_wdata   = 8'($urandom) & 8'($urandom);
         cfg_clr_we  = !cfg_mask_we && ($urandom_range(7) == 0);
         intr_ack    = m_req ? ($urandom_range(1) == 1) : ($urandom_range(15) == 0);
         intr_ret    = ($urandom_range(5) == 0);
         reset       = ($urandom_range(99) != 0);
         tick();
      end
      reset = 1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
